// File: rtl/dmem_pkg.sv
// Shared types and helpers for the wait-stated data-memory responder.
// State enum, wait-counter width and index-width helper.
package dmem_pkg;

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  localparam int CNT_W = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// M-stage data-memory bus between the datapath (master)
// and the wait-stated responder (slave).
interface dmem_responder_if;
  logic        ReqValid;
  logic        ReqWrite;
  logic [31:0] Addr;
  logic [31:0] WData;
  logic [31:0] RData;
  logic        RDataValid;
  logic        MemStall;
  logic        MisalignErr;
  logic [15:0] test_value;

  modport master (
    output ReqValid, ReqWrite, Addr, WData,
    input  RData, RDataValid, MemStall,
    input  MisalignErr, test_value
  );

  modport slave (
    input  ReqValid, ReqWrite, Addr, WData,
    output RData, RDataValid, MemStall,
    output MisalignErr, test_value
  );
endinterface

// File: rtl/dmem_responder_array.sv
// Word storage: async-reset, combinational read port,
// synchronous write port and a fixed debug tap.
module dmem_array #(
  parameter int DEPTH     = 64,
  parameter int IDX_W     = 6,
  parameter int TEST_ADDR = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] ridx,
  output logic [31:0]      rdata,
  output logic [15:0]      test_value
);

  localparam logic [IDX_W-1:0] TIDX = IDX_W'(TEST_ADDR);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[widx] <= wdata;
    end
  end

  assign rdata      = mem[ridx];
  assign test_value = mem[TIDX][15:0];

endmodule

// File: rtl/dmem_responder.sv
// Wait-stated data-memory responder: stalls the pipeline for
// WAIT_CYCLES per access, then completes the load or store.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2,
  parameter int TEST_ADDR   = 0
) (
  input  logic             CLK,
  input  logic             RST,
  dmem_responder_if.slave  bus
);

  localparam int IDX_W = clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               lat_write;
  logic [IDX_W-1:0]   lat_idx;
  logic [31:0]        lat_wdata;
  logic [IDX_W-1:0]   req_idx;
  logic               op_write;
  logic [IDX_W-1:0]   op_idx;
  logic [31:0]        op_wdata;
  logic               accept;
  logic               done;
  logic               stall;
  logic               wr_en;
  logic               load_done;
  logic [31:0]        arr_rdata;
  logic [31:0]        rdata_q;
  logic               err_q;
  logic               unused_addr;

  assign req_idx     = bus.Addr[IDX_W+1:2];
  assign unused_addr = ^bus.Addr[31:IDX_W+2];
  assign accept      = (state == IDLE) && bus.ReqValid;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    stall    = 1'b0;
    done     = 1'b0;
    op_write = lat_write;
    op_idx   = lat_idx;
    op_wdata = lat_wdata;
    unique case (state)
      IDLE: begin
        if (bus.ReqValid) begin
          if (WAIT_CYCLES == 0) begin
            done     = 1'b1;
            op_write = bus.ReqWrite;
            op_idx   = req_idx;
            op_wdata = bus.WData;
          end else begin
            stall   = 1'b1;
            state_n = WAIT;
            cnt_n   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt != '0) begin
          stall = 1'b1;
          cnt_n = cnt - CNT_W'(1);
        end else begin
          done    = 1'b1;
          state_n = IDLE;
        end
      end
    endcase
  end

  // Completion is suppressed while RST is held so nothing leaks out.
  assign wr_en     = done & op_write & ~RST;
  assign load_done = done & ~op_write & ~RST;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_write <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        lat_write <= bus.ReqWrite;
        lat_idx   <= req_idx;
        lat_wdata <= bus.WData;
        if (bus.Addr[1:0] != 2'b00) err_q <= 1'b1;
      end
      if (load_done) rdata_q <= arr_rdata;
    end
  end

  dmem_array #(
    .DEPTH     (DEPTH_WORDS),
    .IDX_W     (IDX_W),
    .TEST_ADDR (TEST_ADDR)
  ) u_array (
    .clk        (CLK),
    .rst        (RST),
    .we         (wr_en),
    .widx       (op_idx),
    .wdata      (op_wdata),
    .ridx       (op_idx),
    .rdata      (arr_rdata),
    .test_value (bus.test_value)
  );

  assign bus.RData       = load_done ? arr_rdata : rdata_q;
  assign bus.RDataValid  = load_done;
  assign bus.MemStall    = stall & ~RST;
  assign bus.MisalignErr = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (W=2,0,3) share one
// stimulus stream and are checked against a cycle-count memory model.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst;
  logic rv, wr;
  logic [31:0] addr, wdat;

  always #5 clk = ~clk;

  dmem_responder_if bus0 ();
  dmem_responder_if bus1 ();
  dmem_responder_if bus2 ();

  assign bus0.ReqValid = rv;
  assign bus0.ReqWrite = wr;
  assign bus0.Addr     = addr;
  assign bus0.WData    = wdat;
  assign bus1.ReqValid = rv;
  assign bus1.ReqWrite = wr;
  assign bus1.Addr     = addr;
  assign bus1.WData    = wdat;
  assign bus2.ReqValid = rv;
  assign bus2.ReqWrite = wr;
  assign bus2.Addr     = addr;
  assign bus2.WData    = wdat;

  dmem_responder #(
    .DEPTH_WORDS (64), .WAIT_CYCLES (2), .TEST_ADDR (0)
  ) u_w2 (.CLK (clk), .RST (rst), .bus (bus0));

  dmem_responder #(
    .DEPTH_WORDS (64), .WAIT_CYCLES (0), .TEST_ADDR (0)
  ) u_w0 (.CLK (clk), .RST (rst), .bus (bus1));

  dmem_responder #(
    .DEPTH_WORDS (64), .WAIT_CYCLES (3), .TEST_ADDR (0)
  ) u_w3 (.CLK (clk), .RST (rst), .bus (bus2));

  logic [2:0]  stall, rdv, err;
  logic [31:0] rd [3];
  logic [15:0] tv [3];

  assign stall = {bus2.MemStall, bus1.MemStall, bus0.MemStall};
  assign rdv   = {bus2.RDataValid, bus1.RDataValid, bus0.RDataValid};
  assign err   = {bus2.MisalignErr, bus1.MisalignErr, bus0.MisalignErr};
  assign rd[0] = bus0.RData;
  assign rd[1] = bus1.RData;
  assign rd[2] = bus2.RData;
  assign tv[0] = bus0.test_value;
  assign tv[1] = bus1.test_value;
  assign tv[2] = bus2.test_value;

  function automatic int wof(input int k);
    case (k)
      0:       return 2;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  // Reference model: memory image plus "completes at cycle N" bookkeeping.
  logic [31:0] mmem [3][64];
  bit          busy [3];
  int          due  [3];
  bit          lw   [3];
  int          li   [3];
  logic [31:0] ld   [3];
  logic [31:0] lastr[3];
  bit          merr [3];
  int          cyc;

  logic        s_stall [3];
  logic        s_rdv   [3];
  logic [31:0] s_rd    [3];
  logic        s_err   [3];
  logic [15:0] s_tv    [3];

  int nvec = 0;
  int nbad = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 64; i++) mmem[k][i] = '0;
      busy[k]  = 1'b0;
      due[k]   = 0;
      lw[k]    = 1'b0;
      li[k]    = 0;
      ld[k]    = '0;
      lastr[k] = '0;
      merr[k]  = 1'b0;
    end
  endtask

  task automatic step(input logic v, input logic w,
                      input logic [31:0] a, input logic [31:0] d);
    bit          fin [3];
    bit          fw  [3];
    int          fi  [3];
    logic [31:0] fd  [3];
    logic [31:0] er  [3];
    bit          acc [3];
    bit          es, ev;
    rv = v; wr = w; addr = a; wdat = d;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      acc[k] = !busy[k] && v;
      fin[k] = 1'b0; fw[k] = 1'b0; fi[k] = 0; fd[k] = '0;
      es = 1'b0;
      if (busy[k]) begin
        if (cyc < due[k]) es = 1'b1;
        else begin
          fin[k] = 1'b1; fw[k] = lw[k];
          fi[k] = li[k]; fd[k] = ld[k];
        end
      end else if (v) begin
        if (wof(k) == 0) begin
          fin[k] = 1'b1; fw[k] = w;
          fi[k] = int'(a[7:2]); fd[k] = d;
        end else es = 1'b1;
      end
      ev    = fin[k] && !fw[k];
      er[k] = ev ? mmem[k][fi[k]] : lastr[k];
      s_stall[k] = stall[k]; s_rdv[k] = rdv[k]; s_rd[k] = rd[k];
      s_err[k] = err[k]; s_tv[k] = tv[k];
      chk($sformatf("k%0d_stall@%0d", k, cyc), 32'(stall[k]), 32'(es));
      chk($sformatf("k%0d_rdv@%0d", k, cyc), 32'(rdv[k]), 32'(ev));
      chk($sformatf("k%0d_rdata@%0d", k, cyc), rd[k], er[k]);
      chk($sformatf("k%0d_err@%0d", k, cyc), 32'(err[k]), 32'(merr[k]));
      chk($sformatf("k%0d_tv@%0d", k, cyc), 32'(tv[k]),
          32'(mmem[k][0][15:0]));
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (acc[k] && a[1:0] != 2'b00) merr[k] = 1'b1;
      if (fin[k]) begin
        busy[k] = 1'b0;
        if (fw[k]) mmem[k][fi[k]] = fd[k];
        else lastr[k] = er[k];
      end
      if (acc[k] && wof(k) != 0) begin
        busy[k] = 1'b1; due[k] = cyc + wof(k);
        lw[k] = w; li[k] = int'(a[7:2]); ld[k] = d;
      end
    end
    cyc++;
  endtask

  // Hold one request for the W=2 instance's full latency, then idle once.
  task automatic xfer(input logic w, input logic [31:0] a,
                      input logic [31:0] d, output logic [2:0] pat,
                      output logic [2:0] vpat, output logic [31:0] rdl,
                      output logic [15:0] tvd);
    pat = '0; vpat = '0; rdl = '0; tvd = '0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, w, a, d);
      pat  = {pat[1:0], s_stall[0]};
      vpat = {vpat[1:0], s_rdv[0]};
      if (i == 2) begin
        rdl = s_rd[0];
        tvd = s_tv[0];
      end
    end
    step(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    logic [2:0]  pat, vpat;
    logic [31:0] rdl, a;
    logic [15:0] tvd;
    logic [5:0]  p2;
    logic [7:0]  p3;
    int          c0, c2;

    rv = 1'b0; wr = 1'b0; addr = '0; wdat = '0;
    cyc = 0;
    rst = 1'b1;
    model_reset();
    #12;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_k%0d_rdata", k), rd[k], 32'h0);
      chk($sformatf("rst_k%0d_flags", k),
          32'({stall[k], rdv[k], err[k]}), 32'h0);
      chk($sformatf("rst_k%0d_tv", k), 32'(tv[k]), 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    xfer(1'b1, 32'h10, 32'hDEADBEEF, pat, vpat, rdl, tvd);
    xfer(1'b0, 32'h10, 32'h0, pat, vpat, rdl, tvd);
    chk("w2_load_stall_pat", 32'(pat), 32'(3'b110));
    chk("w2_load_rdv_pat", 32'(vpat), 32'(3'b001));
    chk("w2_load_rdata", rdl, 32'hDEADBEEF);

    xfer(1'b1, 32'h0, 32'h0000ABCD, pat, vpat, rdl, tvd);
    chk("w2_store_stall_pat", 32'(pat), 32'(3'b110));
    chk("w2_tv_before_commit", 32'(tvd), 32'h0);
    chk("w2_tv_after_commit", 32'(s_tv[0]), 32'h0000ABCD);

    step(1'b1, 1'b1, 32'h10, 32'h12345678);
    step(1'b1, 1'b0, 32'h10, 32'h0);
    chk("w0_same_cycle_rdata", s_rd[1], 32'h12345678);
    chk("w0_same_cycle_rdv", 32'(s_rdv[1]), 32'h1);
    chk("w0_no_stall", 32'(s_stall[1]), 32'h0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 32'h0);

    xfer(1'b1, 32'h104, 32'h55, pat, vpat, rdl, tvd);
    xfer(1'b0, 32'h006, 32'h0, pat, vpat, rdl, tvd);
    chk("wrap_rdata", rdl, 32'h55);
    chk("misalign_set", 32'(s_err[0]), 32'h1);
    step(1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0);
    chk("misalign_sticky", 32'(s_err[0]), 32'h1);

    step(1'b1, 1'b1, 32'h08, 32'h77);
    rst = 1'b1;
    #1;
    chk("rst_mid_stall_w2", 32'(stall[0]), 32'h0);
    chk("rst_mid_stall_w3", 32'(stall[2]), 32'h0);
    rv = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    xfer(1'b0, 32'h08, 32'h0, pat, vpat, rdl, tvd);
    chk("rst_store_dropped", rdl, 32'h0);
    chk("rst_clears_err", 32'(s_err[0]), 32'h0);

    p2 = '0; p3 = '0; c0 = 0; c2 = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 32'h20, 32'h0);
      if (i < 6) begin
        p2 = {p2[4:0], s_stall[0]};
        c0 += int'(s_rdv[0]);
      end
      p3 = {p3[6:0], s_stall[2]};
      c2 += int'(s_rdv[2]);
    end
    chk("b2b_w2_stall_pat", 32'(p2), 32'(6'b110110));
    chk("b2b_w3_stall_pat", 32'(p3), 32'(8'b11101110));
    chk("b2b_w2_rdv_count", c0, 2);
    chk("b2b_w3_rdv_count", c2, 2);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 32'h0);

    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      if ($urandom_range(7) != 0) a[1:0] = 2'b00;
      step(1'($urandom_range(9) < 6), 1'($urandom_range(1)), a, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Wait-stated data-memory responder. It serves the memory-stage load/store requests issued by the pipelined MIPS datapath.
- While an access is in progress it stalls the pipeline through MemStall, which the hazard unit ORs into StallF/StallD and the M-stage hold.
- It returns the word read and drives the 16-bit test_value debug tap.
- It replaces the zero-wait data memory, so the memory side can model slower storage.

Parameters:
DEPTH_WORDS, 64, number of 32-bit words; must be a power of two, at least 2.
WAIT_CYCLES, 2, stall cycles per access; 0 to 15 allowed.
TEST_ADDR, 0, word index whose low half drives test_value.

Ports:
CLK  in  1  clock, rising-edge.
RST  in  1  asynchronous active-high reset.
ReqValid  in  1  M-stage access request; the datapath drives MemWriteM OR MemtoRegM.
ReqWrite  in  1  1 = store, 0 = load; valid only when ReqValid is 1.
Addr  in  32  byte address (ALUOutM).
WData  in  32  store data (WriteDataM).
RData  out  32  load data (ReadDataM).
RDataValid  out  1  load completes this cycle.
MemStall  out  1  hold the pipeline this cycle.
MisalignErr  out  1  sticky flag: an access with Addr[1:0] != 0 was seen.
test_value  out  16  mem[TEST_ADDR][15:0].

Behaviour:
- Reset state:
  - All memory words are 0. State is IDLE and the counter is 0.
  - RData = 0, RDataValid = 0, MemStall = 0, MisalignErr = 0, test_value = 0.
- Address mapping:
  - Word index = Addr[log2(DEPTH_WORDS)+1:2].
  - Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
  - Addr[1:0] is ignored for the access itself.
  - Addr[1:0] != 0 sets MisalignErr on the accepting edge; the flag is cleared only by RST.
- States: IDLE and WAIT.
  - IDLE, no ReqValid: MemStall = 0, RDataValid = 0, RData holds its last value.
  - IDLE, ReqValid with WAIT_CYCLES = 0: the access completes in the same cycle.
    - Load: RData = mem[idx] combinationally and RDataValid = 1.
    - Store: the write commits at the closing edge.
    - MemStall stays 0 and the state stays IDLE.
  - IDLE, ReqValid with WAIT_CYCLES > 0: MemStall = 1 combinationally in that cycle.
    - At the edge: latch ReqWrite, idx and WData; cnt <= WAIT_CYCLES-1; go to WAIT.
  - WAIT with cnt != 0: MemStall = 1, cnt decrements, request inputs are ignored.
  - WAIT with cnt == 0 (completion cycle): MemStall = 0.
    - Load: RData = mem[latched idx] and RDataValid = 1.
    - Store: the write commits at the closing edge.
    - Go to IDLE.
- Latency: a request first presented in cycle 0 stalls cycles 0 to W-1 and completes in cycle W (W = WAIT_CYCLES).
- RData after completion: the registered copy of the completed load data is held until the next load completes.
- Back-to-back requests: the pipeline advances at the completion edge. A ReqValid seen in IDLE on the following cycle is a new request and gets a full W-cycle stall; there are no idle bubbles forced between accesses.
- Store-then-load to the same word: the load returns the newly stored value.
- test_value is read combinationally from the array and reflects a store starting the cycle after its commit edge.
- RST asserted mid-access: the state returns to IDLE at once, the pending store is discarded, and MemStall drops asynchronously.
- ReqWrite/Addr changing during WAIT: no effect, because the latched copies are used.

Decomposition:
- Shared package dmem_pkg holds:
  - the state enum (IDLE, WAIT);
  - WAIT counter width constant CNT_W = 4;
  - an index-width function clog2(DEPTH_WORDS).
- One sub-module, dmem_array: storage with asynchronous reset, one combinational read port, one synchronous write port and the test tap. The FSM and stall logic stay in dmem_responder.

Test Plan:
- Load with W = 2: store 0xDEADBEEF to 0x10 completes, then load 0x10 -> MemStall = 1 for 2 cycles, then RDataValid = 1 with RData = 0xDEADBEEF on the third cycle.
- Store with W = 2: store 0x0000ABCD to 0x00, TEST_ADDR = 0 -> MemStall for 2 cycles; test_value = 0xABCD starting the cycle after the completion edge.
- W = 0: load 0x10 right after a store of 0x12345678 to 0x10 -> same-cycle RData = 0x12345678, RDataValid = 1, MemStall never asserted.
- Wrap and misalignment, DEPTH_WORDS = 64: store 0x55 to 0x104, then load 0x006 -> RData = 0x55 and MisalignErr = 1, staying 1 until RST.
- Reset mid-access: store 0x77 to 0x08, assert RST during WAIT, release, then load 0x08 -> RData = 0 and MemStall = 0 immediately on RST.
- Back-to-back loads with W = 3: hold ReqValid high for two consecutive loads -> MemStall pattern 1,1,1,0,1,1,1,0 and two RDataValid pulses.
